// File: rtl/expr_pkg.sv
// Shared types and ASCII constants for the character-stream expression sequencer
// and the recognizer path.
package expr_pkg;

  typedef enum logic [1:0] {
    S_NUM,
    S_OP,
    S_ERR,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    C_DIGIT,
    C_PLUS,
    C_STAR,
    C_EQ,
    C_OTHER
  } char_cls_e;

  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_9    = 8'h39;
  localparam logic [7:0] ASCII_PLUS = 8'h2B;
  localparam logic [7:0] ASCII_STAR = 8'h2A;
  localparam logic [7:0] ASCII_EQ   = 8'h3D;

endpackage

// File: rtl/expr_char_class.sv
// Combinational ASCII classifier: maps one character to its class and,
// for '0'..'9', its numeric value.
module expr_char_class
  import expr_pkg::*;
(
  input  logic [7:0] in_char,
  output char_cls_e  char_cls,
  output logic [3:0] digit
);

  logic [7:0] offset;

  always_comb begin
    char_cls = C_OTHER;
    digit    = 4'd0;
    offset   = in_char - ASCII_0;
    if ((in_char >= ASCII_0) && (in_char <= ASCII_9)) begin
      char_cls = C_DIGIT;
      digit    = offset[3:0];
    end else if (in_char == ASCII_PLUS) begin
      char_cls = C_PLUS;
    end else if (in_char == ASCII_STAR) begin
      char_cls = C_STAR;
    end else if (in_char == ASCII_EQ) begin
      char_cls = C_EQ;
    end
  end

endmodule

// File: rtl/expr_seq.sv
// Expression sequencer: checks digit (op digit)* and evaluates with '*' binding
// tighter than '+'; the result or an error flag is delivered on '='.
//   state  | meaning
//   S_NUM  | expecting a single digit
//   S_OP   | expecting '+', '*' or '='; accepted text is a complete expression
//   S_ERR  | malformed; discard characters until '='
//   S_DONE | result held until downstream takes it
module expr_seq
  import expr_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [7:0]   in_char,
  output logic         in_ready,
  output logic         ok,
  output logic         res_valid,
  output logic [W-1:0] res_value,
  output logic         res_err,
  input  logic         res_ready
);

  state_e         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   term_q, term_d;
  logic           mul_pend_q, mul_pend_d;
  logic [W-1:0]   res_value_q, res_value_d;
  logic           res_err_q, res_err_d;

  char_cls_e      char_cls;
  logic [3:0]     digit;
  logic           accept;
  logic [W+3:0]   prod_full;
  logic [W-1:0]   sum;

  expr_char_class u_char_class (
    .in_char  (in_char),
    .char_cls (char_cls),
    .digit    (digit)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    term_d      = term_q;
    mul_pend_d  = mul_pend_q;
    res_value_d = res_value_q;
    res_err_d   = res_err_q;

    in_ready  = (state_q != S_DONE);
    ok        = (state_q == S_OP);
    res_valid = (state_q == S_DONE);
    accept    = in_valid & in_ready;

    prod_full = {4'b0, term_q} * {{W{1'b0}}, digit};
    sum       = acc_q + term_q;

    case (state_q)
      S_NUM: begin
        if (accept) begin
          case (char_cls)
            C_DIGIT: begin
              term_d     = mul_pend_q ? prod_full[W-1:0] : W'(digit);
              mul_pend_d = 1'b0;
              state_d    = S_OP;
            end
            C_EQ: begin
              res_value_d = '0;
              res_err_d   = 1'b1;
              state_d     = S_DONE;
            end
            default: state_d = S_ERR;
          endcase
        end
      end
      S_OP: begin
        if (accept) begin
          case (char_cls)
            C_PLUS: begin
              acc_d   = sum;
              term_d  = '0;
              state_d = S_NUM;
            end
            C_STAR: begin
              mul_pend_d = 1'b1;
              state_d    = S_NUM;
            end
            C_EQ: begin
              res_value_d = sum;
              res_err_d   = 1'b0;
              state_d     = S_DONE;
            end
            default: state_d = S_ERR;
          endcase
        end
      end
      S_ERR: begin
        if (accept && (char_cls == C_EQ)) begin
          res_value_d = '0;
          res_err_d   = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        // Expression registers clear on handshake so the next one starts fresh
        if (res_ready) begin
          acc_d      = '0;
          term_d     = '0;
          mul_pend_d = 1'b0;
          state_d    = S_NUM;
        end
      end
      default: state_d = S_NUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= S_NUM;
      acc_q       <= '0;
      term_q      <= '0;
      mul_pend_q  <= 1'b0;
      res_value_q <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      term_q      <= term_d;
      mul_pend_q  <= mul_pend_d;
      res_value_q <= res_value_d;
      res_err_q   <= res_err_d;
    end
  end

  assign res_value = res_value_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_expr_seq.sv
// Self-checking bench for expr_seq: table vectors, random expressions against a
// string-level evaluator, and hand-written handshake/clear sequences.
module tb_expr_seq;

  logic        clk;
  logic        clr;
  logic        in_valid;
  logic [7:0]  in_char;
  logic        res_ready;
  logic        in_ready, ok, res_valid, res_err;
  logic [15:0] res_value;
  logic        in_ready8, ok8, res_valid8, res_err8;
  logic [7:0]  res_value8;

  int checks = 0;
  int errors = 0;

  expr_seq #(.W(16)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_char(in_char),
    .in_ready(in_ready), .ok(ok), .res_valid(res_valid),
    .res_value(res_value), .res_err(res_err), .res_ready(res_ready)
  );

  expr_seq #(.W(8)) dut8 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_char(in_char),
    .in_ready(in_ready8), .ok(ok8), .res_valid(res_valid8),
    .res_value(res_value8), .res_err(res_err8), .res_ready(res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       expr;
    int unsigned exp16;
    int unsigned exp8;
    bit          err;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_digit(input byte c);
    return (c >= "0") && (c <= "9");
  endfunction

  function automatic bit legal(input byte q[$]);
    if ((q.size() % 2) == 0) return 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      if ((i % 2) == 0 && !is_digit(q[i])) return 1'b0;
      if ((i % 2) == 1 && q[i] != "+" && q[i] != "*") return 1'b0;
    end
    return 1'b1;
  endfunction

  // Sum of products, modulo 2^16 (low byte gives the W=8 answer).
  function automatic void model(input byte q[$], output bit err, output int unsigned v);
    int unsigned sum, prod, d;
    err = !legal(q);
    v   = 0;
    if (err) return;
    sum  = 0;
    prod = int'(q[0]) - 48;
    for (int i = 1; i < q.size(); i += 2) begin
      d = int'(q[i+1]) - 48;
      if (q[i] == "*") prod = (prod * d) & 32'hFFFF;
      else begin
        sum  = (sum + prod) & 32'hFFFF;
        prod = d;
      end
    end
    v = (sum + prod) & 32'hFFFF;
  endfunction

  // Present a character at a negedge, wait (bounded) for in_ready, consume it.
  task automatic send_char(input byte c);
    int n = 0;
    in_valid = 1'b1;
    in_char  = c;
    while (!in_ready && n < 20) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_expr(input string s, output logic [15:0] v16,
                          output logic [7:0] v8, output logic e);
    byte q[$];
    byte c;
    v16 = '0; v8 = '0; e = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      send_char(c);
      if (c != "=") begin
        q.push_back(c);
        chk({"ok_after_", s}, 32'(ok), 32'(legal(q)));
      end else begin
        chk("res_valid_after_eq", 32'(res_valid), 32'd1);
        chk("in_ready_in_done", 32'(in_ready), 32'd0);
        chk("ok_in_done", 32'(ok), 32'd0);
        v16 = res_value;
        v8  = res_value8;
        e   = res_err;
        chk("err_w8_matches", 32'(res_err8), 32'(res_err));
        @(posedge clk); @(negedge clk);
        chk("res_valid_after_hs", 32'(res_valid), 32'd0);
        chk("in_ready_after_hs", 32'(in_ready), 32'd1);
      end
    end
  endtask

  initial begin
    logic [15:0] v16;
    logic [7:0]  v8;
    logic        e;
    bit          merr;
    int unsigned mv;
    string       s;
    byte         q[$];
    byte         c;
    int          len;
    string       bad_pool;

    tbl[0] = '{"2+3*4=",      14,    14,  1'b0};
    tbl[1] = '{"2*3+4*5=",    26,    26,  1'b0};
    tbl[2] = '{"7=",          7,     7,   1'b0};
    tbl[3] = '{"2++3=",       0,     0,   1'b1};
    tbl[4] = '{"=",           0,     0,   1'b1};
    tbl[5] = '{"12=",         0,     0,   1'b1};
    tbl[6] = '{"2+a=",        0,     0,   1'b1};
    tbl[7] = '{"9*9*9=",      729,   217, 1'b0};
    tbl[8] = '{"9*9*9*9*9=",  59049, 169, 1'b0};
    tbl[9] = '{"0*9+1=",      1,     1,   1'b0};

    clr = 1'b1; in_valid = 1'b0; in_char = 8'h00; res_ready = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    clr = 1'b0;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_ok",        32'(ok),        32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_value", 32'(res_value), 32'd0);
    chk("rst_res_err",   32'(res_err),   32'd0);

    foreach (tbl[i]) begin
      run_expr(tbl[i].expr, v16, v8, e);
      chk({"tbl_val16_", tbl[i].expr}, 32'(v16), 32'(tbl[i].exp16));
      chk({"tbl_val8_",  tbl[i].expr}, 32'(v8),  32'(tbl[i].exp8));
      chk({"tbl_err_",   tbl[i].expr}, 32'(e),   32'(tbl[i].err));
    end

    bad_pool = "+*x15?";
    for (int n = 0; n < 60; n++) begin
      s = "";
      q.delete();
      len = $urandom_range(0, 9);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 11) == 0)
          c = bad_pool[$urandom_range(0, bad_pool.len() - 1)];
        else if ((i % 2) == 0)
          c = 8'(48 + $urandom_range(0, 9));
        else
          c = ($urandom_range(0, 1) == 1) ? "*" : "+";
        q.push_back(c);
        s = {s, " "};
        s[i] = c;
      end
      model(q, merr, mv);
      s = {s, "="};
      run_expr(s, v16, v8, e);
      chk({"rnd_val16_", s}, 32'(v16), mv);
      chk({"rnd_val8_",  s}, 32'(v8),  mv & 32'hFF);
      chk({"rnd_err_",   s}, 32'(e),   32'(merr));
    end

    // Result held under back-pressure while upstream presents '3'.
    res_ready = 1'b0;
    send_char("5");
    send_char("=");
    in_valid = 1'b1;
    in_char  = "3";
    for (int i = 0; i < 4; i++) begin
      chk("stall_in_ready",  32'(in_ready),  32'd0);
      chk("stall_res_valid", 32'(res_valid), 32'd1);
      chk("stall_res_value", 32'(res_value), 32'd5);
      chk("stall_res_err",   32'(res_err),   32'd0);
      @(posedge clk); @(negedge clk);
    end
    res_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("dead_cycle_in_ready", 32'(in_ready),  32'd1);
    chk("dead_cycle_valid",    32'(res_valid), 32'd0);
    chk("dead_cycle_ok",       32'(ok),        32'd0);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("held_char_ok", 32'(ok), 32'd1);
    send_char("=");
    chk("held_char_value", 32'(res_value), 32'd3);
    chk("held_char_valid", 32'(res_valid), 32'd1);
    @(posedge clk); @(negedge clk);

    // Clear mid-expression discards partial term.
    send_char("4");
    send_char("*");
    send_char("6");
    clr = 1'b1;
    @(posedge clk); @(negedge clk);
    clr = 1'b0;
    chk("clr_in_ready",  32'(in_ready),  32'd1);
    chk("clr_ok",        32'(ok),        32'd0);
    chk("clr_res_valid", 32'(res_valid), 32'd0);
    chk("clr_res_value", 32'(res_value), 32'd0);
    chk("clr_res_err",   32'(res_err),   32'd0);
    run_expr("1=", v16, v8, e);
    chk("after_clr_val", 32'(v16), 32'd1);
    chk("after_clr_err", 32'(e),   32'd0);

    // Clear while a result is pending drops it.
    res_ready = 1'b0;
    send_char("8");
    send_char("=");
    chk("pending_valid", 32'(res_valid), 32'd1);
    chk("pending_value", 32'(res_value), 32'd8);
    clr = 1'b1;
    @(posedge clk); @(negedge clk);
    clr = 1'b0;
    res_ready = 1'b1;
    chk("clr_done_valid",    32'(res_valid), 32'd0);
    chk("clr_done_value",    32'(res_value), 32'd0);
    chk("clr_done_in_ready", 32'(in_ready),  32'd1);
    run_expr("3*3+1=", v16, v8, e);
    chk("post_done_clr_val", 32'(v16), 32'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
